// File: rtl/adder_input_packer.sv
// adder_input_packer: packs a serial stream of BITS-wide operands into
// NUM-lane vectors for the fp16 adder. It has a fill buffer and an output
// register, so it sustains one word per cycle and can absorb downstream hold.
// A last_in marker closes a partial vector. Lanes above the last real word
// are padded with +0.0 (all zeros).
// The port list exposes four lanes. For NUM < 4 the unused ports read zero.
module adder_input_packer #(
  parameter int BITS = 16,
  parameter int NUM  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [BITS-1:0]            data_in,
  input  logic                       last_in,
  output logic                       ready_in,
  input  logic                       hold,
  output logic                       valid,
  output logic [BITS-1:0]            data_out__0,
  output logic [BITS-1:0]            data_out__1,
  output logic [BITS-1:0]            data_out__2,
  output logic [BITS-1:0]            data_out__3,
  output logic [$clog2(NUM+1)-1:0]   lanes,
  output logic [15:0]                pkt_count
);

  localparam int IW = $clog2(NUM);
  localparam int LW = $clog2(NUM+1);

  logic [IW-1:0]   idx_q, idx_d;
  logic            fill_full_q, fill_full_d;
  logic            out_full_q, out_full_d;
  logic [LW-1:0]   fill_lanes_q, fill_lanes_d;
  logic [LW-1:0]   lanes_q, lanes_d;
  logic [15:0]     pkt_q, pkt_d;
  logic [BITS-1:0] fill_q [NUM];
  logic [BITS-1:0] fill_d [NUM];
  logic [BITS-1:0] out_q [NUM];
  logic [BITS-1:0] out_d [NUM];
  logic [BITS-1:0] comp_vec [NUM];

  logic            accept;
  logic            complete;
  logic            out_free;
  logic [LW-1:0]   comp_lanes;

  // The fill buffer stalls the producer only when it holds a completed
  // vector that is waiting for the output register.
  assign ready_in   = ~fill_full_q & ~reset;
  assign valid      = out_full_q & ~hold & ~reset;
  assign accept     = valid_in & ready_in;
  assign complete   = accept & (last_in | (idx_q == IW'(NUM-1)));
  // The output register can take a new vector if it is empty or it drains this cycle.
  assign out_free   = ~out_full_q | valid;
  assign comp_lanes = LW'(idx_q) + LW'(1);

  // The completed vector: stored lanes below idx, the incoming word at idx,
  // and zero padding above idx.
  for (genvar gi = 0; gi < NUM; gi++) begin : g_comp
    localparam logic [IW-1:0] LANE = IW'(gi);
    assign comp_vec[gi] = (LANE < idx_q)  ? fill_q[gi] :
                          (LANE == idx_q) ? data_in    : '0;
  end

  // Map the internal lanes onto the fixed output ports.
  assign data_out__0 = out_q[0];
  assign data_out__1 = out_q[1];
  if (NUM > 2) begin : g_l2
    assign data_out__2 = out_q[2];
  end else begin : g_l2_zero
    assign data_out__2 = '0;
  end
  if (NUM > 3) begin : g_l3
    assign data_out__3 = out_q[3];
  end else begin : g_l3_zero
    assign data_out__3 = '0;
  end
  assign lanes     = lanes_q;
  assign pkt_count = pkt_q;

  // Next state: word capture, completion routing, pending transfer, consume.
  always_comb begin
    idx_d        = idx_q;
    fill_full_d  = fill_full_q;
    out_full_d   = out_full_q;
    fill_lanes_d = fill_lanes_q;
    lanes_d      = lanes_q;
    pkt_d        = pkt_q;
    fill_d       = fill_q;
    out_d        = out_q;

    if (accept) begin
      fill_d[idx_q] = data_in;
      idx_d         = complete ? '0 : idx_q + IW'(1);
    end

    if (valid) begin
      out_full_d = 1'b0;
      pkt_d      = pkt_q + 16'd1;
    end

    if (fill_full_q && out_free) begin
      out_d       = fill_q;
      lanes_d     = fill_lanes_q;
      out_full_d  = 1'b1;
      fill_full_d = 1'b0;
    end else if (complete && out_free) begin
      out_d      = comp_vec;
      lanes_d    = comp_lanes;
      out_full_d = 1'b1;
    end else if (complete) begin
      fill_d       = comp_vec;
      fill_lanes_d = comp_lanes;
      fill_full_d  = 1'b1;
    end
  end

  // State registers. Reset discards any partial or buffered vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      fill_full_q  <= 1'b0;
      out_full_q   <= 1'b0;
      fill_lanes_q <= '0;
      lanes_q      <= '0;
      pkt_q        <= '0;
      for (int i = 0; i < NUM; i++) begin
        fill_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      idx_q        <= idx_d;
      fill_full_q  <= fill_full_d;
      out_full_q   <= out_full_d;
      fill_lanes_q <= fill_lanes_d;
      lanes_q      <= lanes_d;
      pkt_q        <= pkt_d;
      fill_q       <= fill_d;
      out_q        <= out_d;
    end
  end

endmodule

// File: tb/tb_adder_input_packer.sv
// Scoreboard bench for adder_input_packer. The reference model collects
// accepted words into a queue and emits a zero-padded expected vector when
// NUM words have arrived or when last_in is seen. A separate monitor checks
// each vector that the DUT presents.
module tb_adder_input_packer;
  localparam int BITS = 16;
  localparam int NUM  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic            valid_in = 1'b0;
  logic [BITS-1:0] data_in = '0;
  logic            last_in = 1'b0;
  logic            ready_in;
  logic            hold = 1'b0;
  logic            valid;
  logic [BITS-1:0] data_out__0, data_out__1, data_out__2, data_out__3;
  logic [2:0]      lanes;
  logic [15:0]     pkt_count;

  adder_input_packer #(.BITS(BITS), .NUM(NUM)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .last_in(last_in), .ready_in(ready_in), .hold(hold), .valid(valid),
    .data_out__0(data_out__0), .data_out__1(data_out__1),
    .data_out__2(data_out__2), .data_out__3(data_out__3),
    .lanes(lanes), .pkt_count(pkt_count)
  );

  typedef struct {
    logic [3:0][15:0] d;
    int               lanes;
  } vec_t;

  vec_t        exp_q[$];
  logic [15:0] part[$];
  int          emitted = 0;
  int          cons_cyc[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          stalls = 0;
  int          acc_n = 0;
  int          last_acc_cyc = 0;
  int          cyc = 0;
  bit          hold_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  // Reference model: a vector is formed from the accepted words, with zero padding.
  function automatic void model_accept(logic [15:0] w, bit l);
    vec_t v;
    part.push_back(w);
    if (part.size() == NUM || l) begin
      v.d = '0;
      for (int i = 0; i < part.size(); i++) v.d[i] = part[i];
      v.lanes = part.size();
      exp_q.push_back(v);
      part.delete();
    end
  endfunction

  // Monitor: each valid cycle is one consume, so it is compared with the queue head.
  initial begin
    vec_t e;
    logic [63:0] got;
    forever begin
      @(negedge clk); #2;
      if (valid) begin
        got = {data_out__3, data_out__2, data_out__1, data_out__0};
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (got !== e.d || int'(lanes) != e.lanes || pkt_count !== emitted[15:0]) begin
            n_fail++;
            $display("FAIL vec: got data=%h lanes=%0d pkt=%0d, required data=%h lanes=%0d pkt=%0d",
                     got, lanes, pkt_count, e.d, e.lanes, emitted[15:0]);
          end
        end
        emitted++;
        cons_cyc.push_back(cyc);
      end
    end
  end

  // Random downstream stall generator used during the random phase.
  initial forever begin
    @(negedge clk);
    if (hold_rand) hold = 1'($urandom_range(0, 1));
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] w, input bit l);
    int g = 0;
    @(negedge clk);
    valid_in = 1'b1; data_in = w; last_in = l;
    #1;
    while (!ready_in) begin
      stalls++;
      g++;
      if (g > 200) begin
        check("send_timeout", 0, 1);
        return;
      end
      @(negedge clk); #1;
    end
    model_accept(w, l);
    @(posedge clk); #1;
    last_acc_cyc = cyc;
    acc_n++;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    #3;
    check("drain_empty", exp_q.size(), 0);
    check("pkt_count", pkt_count, emitted % 65536);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_in = 1'b0; last_in = 1'b0; reset = 1'b1;
    exp_q.delete(); part.delete(); emitted = 0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_ready", ready_in, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", ready_in, 1);
    check("post_rst_data", {data_out__3, data_out__2, data_out__1, data_out__0}, 0);
    check("post_rst_lanes", lanes, 0);
    check("post_rst_pkt", pkt_count, 0);
  endtask

  initial begin
    logic [15:0] t1[4];
    int n0;
    t1 = '{16'h36ac, 16'h39c3, 16'h077f, 16'h34d6};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("init_valid", valid, 0);
    check("init_ready", ready_in, 0);
    do_reset();

    // 1: one full vector, latency of one cycle
    stalls = 0; n0 = cons_cyc.size();
    for (int i = 0; i < 4; i++) send(t1[i], 0);
    idle();
    drain();
    check("t1_count", cons_cyc.size() - n0, 1);
    check("t1_latency", cons_cyc[$], last_acc_cyc);
    check("t1_stalls", stalls, 0);
    check("t1_pkt", pkt_count, 1);

    // 2: back-to-back vectors, spaced 4 cycles apart
    stalls = 0; n0 = cons_cyc.size();
    for (int i = 0; i < 16; i++) send(16'($urandom), 0);
    idle();
    drain();
    check("t2_count", cons_cyc.size() - n0, 4);
    for (int i = n0 + 1; i < cons_cyc.size(); i++)
      check("t2_spacing", cons_cyc[i] - cons_cyc[i-1], 4);
    check("t2_stalls", stalls, 0);

    // 3: partial vector, then a new vector starting at lane 0
    send(16'h3659, 0);
    send(16'h384f, 1);
    idle();
    drain();
    check("t3_latency", cons_cyc[$], last_acc_cyc);
    for (int i = 0; i < 4; i++) send(16'h3000 + 16'(i), 0);
    idle();
    drain();

    // 4: backpressure holds two vectors, then releases in order
    @(negedge clk);
    hold = 1'b1;
    acc_n = 0; n0 = cons_cyc.size();
    fork
      begin
        for (int i = 0; i < 12; i++) send(16'($urandom), 0);
        idle();
      end
      begin
        wait (acc_n == 8);
        @(negedge clk); #1;
        check("t4_ready_drop", ready_in, 0);
        repeat (4) @(negedge clk);
        #1;
        check("t4_ready_low", ready_in, 0);
        check("t4_acc_held", acc_n, 8);
        @(negedge clk);
        hold = 1'b0;
      end
    join
    drain();
    check("t4_count", cons_cyc.size() - n0, 3);
    check("t4_ab_adjacent", cons_cyc[n0+1] - cons_cyc[n0], 1);

    // 5: reset mid-vector discards the partial vector
    send(16'h328b, 0);
    send(16'h3b06, 0);
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h3800 + 16'(i), 0);
    idle();
    drain();

    // Random phase: random gaps, last markers, and hold
    hold_rand = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(16'($urandom), ($urandom_range(0, 4) == 0));
    end
    send(16'h1234, 1);
    idle();
    @(negedge clk);
    hold_rand = 0; hold = 1'b0;
    drain();

    // 6: one-lane vector, then pkt_count wraps after 65536 vectors
    send(16'h3c00, 1);
    idle();
    drain();
    do_reset();
    for (int i = 0; i < 65536; i++) send(16'($urandom), 1);
    idle();
    drain();
    check("t6_emitted", emitted, 65536);
    check("t6_wrap", pkt_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
